// File: rtl/proc_control_fsm_if.sv
// Control bundle between the instruction sequencer and the datapath.
// Handshake: run is sampled only while busy=0; done pulses for one cycle when an instruction ends.
interface proc_control_fsm_if #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
);
  logic              run;
  logic [DATA_W-1:0] din;
  logic [2:0]        rout;
  logic              gout;
  logic              din_enable;
  logic [NREG-1:0]   rin;
  logic              ain;
  logic              gin;
  logic [1:0]        alu_op;
  logic              done;
  logic              busy;
  logic [DATA_W-1:0] ir;
  logic [1:0]        state;

  modport master (
    input  run, din,
    output rout, gout, din_enable, rin, ain, gin, alu_op, done, busy, ir, state
  );

  modport slave (
    output run, din,
    input  rout, gout, din_enable, rin, ain, gin, alu_op, done, busy, ir, state
  );
endinterface

// File: rtl/proc_control_fsm.sv
// Instruction sequencer: latches an instruction into ir and steps the datapath
// select and load strobes through one to three execute cycles.
module proc_control_fsm #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input logic                clk,
  input logic                rst_n,
  proc_control_fsm_if.master bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_T1 = 2'd1, S_T2 = 2'd2, S_T3 = 2'd3} state_t;

  state_t            state;
  logic [DATA_W-1:0] ir_q;
  logic [2:0]        opcode, rx, ry;
  logic              is_alu;
  logic [1:0]        alu_sel;
  logic [NREG-1:0]   rx_onehot;

  logic [2:0]        rout;
  logic              gout, din_enable, ain, gin, done, busy;
  logic [NREG-1:0]   rin;
  logic [1:0]        alu_op;

  assign opcode    = ir_q[DATA_W-1 -: 3];
  assign rx        = ir_q[DATA_W-4 -: 3];
  assign ry        = ir_q[DATA_W-7 -: 3];
  assign is_alu    = (opcode == 3'b010) || (opcode == 3'b011) || (opcode == 3'b100);
  assign rx_onehot = NREG'(1) << rx;

  always_comb begin
    case (opcode)
      3'b011:  alu_sel = 2'b01;
      3'b100:  alu_sel = 2'b10;
      default: alu_sel = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.run) begin
            ir_q  <= bus.din;
            state <= S_T1;
          end
        end
        S_T1:    state <= is_alu ? S_T2 : S_IDLE;
        S_T2:    state <= S_T3;
        S_T3:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state/ir so an async reset clears them in the same cycle.
  always_comb begin
    rout       = 3'd0;
    gout       = 1'b0;
    din_enable = 1'b0;
    rin        = '0;
    ain        = 1'b0;
    gin        = 1'b0;
    alu_op     = 2'b00;
    done       = 1'b0;
    busy       = 1'b0;
    case (state)
      S_T1: begin
        busy = 1'b1;
        case (opcode)
          3'b000: begin
            rout = ry;
            rin  = rx_onehot;
            done = 1'b1;
          end
          3'b001: begin
            din_enable = 1'b1;
            rin        = rx_onehot;
            done       = 1'b1;
          end
          3'b010, 3'b011, 3'b100: begin
            rout = rx;
            ain  = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      S_T2: begin
        busy   = 1'b1;
        rout   = ry;
        gin    = 1'b1;
        alu_op = alu_sel;
      end
      S_T3: begin
        busy   = 1'b1;
        gout   = 1'b1;
        rin    = rx_onehot;
        alu_op = alu_sel;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rout       = rout;
  assign bus.gout       = gout;
  assign bus.din_enable = din_enable;
  assign bus.rin        = rin;
  assign bus.ain        = ain;
  assign bus.gin        = gin;
  assign bus.alu_op     = alu_op;
  assign bus.done       = done;
  assign bus.busy       = busy;
  assign bus.ir         = ir_q;
  assign bus.state      = state;

endmodule
